reg_file_sequencer: RTL and testbench

//  Initiator side of the 2-read/1-write register file interface. Accepts one

---
 rtl/reg_file_sequencer.sv | 119 +++++++++++
 tb/tb_reg_file_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_sequencer.sv
// Instruction sequencer for a 2-read/1-write register file: accepts one
// instruction, reads both operands, computes the ALU result and writes it back.
module reg_file_sequencer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [1:0]        instr_op,
   input  logic [ADDR_W-1:0] instr_src1,
   input  logic [ADDR_W-1:0] instr_src2,
   input  logic [ADDR_W-1:0] instr_dst,
   output logic [ADDR_W-1:0] reg_read_add1,
   output logic [ADDR_W-1:0] reg_read_add2,
   input  logic [DATA_W-1:0] reg_read_data1,
   input  logic [DATA_W-1:0] reg_read_data2,
   output logic              write_en,
   output logic [ADDR_W-1:0] reg_write_add,
   output logic [DATA_W-1:0] reg_write_data,
   output logic              done,
   output logic              carry,
   output logic              zero
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;

   state_t              state, state_next;
   logic [1:0]          op_reg;
   logic [ADDR_W-1:0]   dst_reg;
   logic [DATA_W-1:0]   op_a_reg, op_b_reg, result_reg;
   logic [DATA_W:0]     alu_sum, alu_diff;
   logic [DATA_W-1:0]   alu_result;
   logic                alu_carry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next  = state;
      instr_ready = 1'b0;
      write_en    = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_next = READ;
         end
         READ:  state_next = EXEC;
         EXEC:  state_next = WRITE;
         WRITE: begin
            write_en   = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Bit DATA_W of the widened difference is the borrow, i.e. op_a < op_b.
   always_comb begin
      alu_sum    = {1'b0, op_a_reg} + {1'b0, op_b_reg};
      alu_diff   = {1'b0, op_a_reg} - {1'b0, op_b_reg};
      alu_result = op_a_reg | op_b_reg;
      alu_carry  = 1'b0;
      case (op_reg)
         OP_ADD: {alu_carry, alu_result} = alu_sum;
         OP_SUB: {alu_carry, alu_result} = alu_diff;
         OP_AND: alu_result = op_a_reg & op_b_reg;
         default: alu_result = op_a_reg | op_b_reg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_reg        <= '0;
         dst_reg       <= '0;
         reg_read_add1 <= '0;
         reg_read_add2 <= '0;
         op_a_reg      <= '0;
         op_b_reg      <= '0;
         result_reg    <= '0;
         carry         <= 1'b0;
         zero          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  op_reg        <= instr_op;
                  dst_reg       <= instr_dst;
                  reg_read_add1 <= instr_src1;
                  reg_read_add2 <= instr_src2;
               end
            end
            READ: begin
               op_a_reg <= reg_read_data1;
               op_b_reg <= reg_read_data2;
            end
            EXEC: begin
               result_reg <= alu_result;
               carry      <= alu_carry;
               zero       <= (alu_result == '0);
            end
            default: ;
         endcase
      end
   end

   assign reg_write_add  = dst_reg;
   assign reg_write_data = result_reg;

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Directed bench for reg_file_sequencer with a small behavioural register file
// (combinational read, write on the clock edge while write_en is high).
module tb_reg_file_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [1:0] instr_op = 2'b00;
   logic [1:0] instr_src1 = 2'd0, instr_src2 = 2'd0, instr_dst = 2'd0;
   logic [1:0] reg_read_add1, reg_read_add2, reg_write_add;
   logic [7:0] reg_read_data1, reg_read_data2, reg_write_data;
   logic       write_en, done, carry, zero;

   logic       pre_en = 1'b0;
   logic [1:0] pre_add = 2'd0;
   logic [7:0] pre_data = 8'h00;
   logic [7:0] rf [4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_file_sequencer #(.DATA_W(8), .ADDR_W(2)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_src1(instr_src1), .instr_src2(instr_src2), .instr_dst(instr_dst),
      .reg_read_add1(reg_read_add1), .reg_read_add2(reg_read_add2),
      .reg_read_data1(reg_read_data1), .reg_read_data2(reg_read_data2),
      .write_en(write_en), .reg_write_add(reg_write_add), .reg_write_data(reg_write_data),
      .done(done), .carry(carry), .zero(zero)
   );

   assign reg_read_data1 = rf[reg_read_add1];
   assign reg_read_data2 = rf[reg_read_add2];

   always @(posedge clk) begin
      if (write_en)    rf[reg_write_add] <= reg_write_data;
      else if (pre_en) rf[pre_add] <= pre_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic preload(input logic [1:0] a, input logic [7:0] d);
      pre_en = 1'b1; pre_add = a; pre_data = d;
      tick();
      pre_en = 1'b0;
   endtask

   // One instruction end to end; the accepting edge is E0.
   task automatic run(input string tag, input logic [1:0] op, input logic [1:0] s1,
                      input logic [1:0] s2, input logic [1:0] d, input logic [7:0] exp_data,
                      input logic exp_c, input logic exp_z);
      check({tag, ".ready_idle"}, instr_ready, 1);
      instr_valid = 1'b1; instr_op = op; instr_src1 = s1; instr_src2 = s2; instr_dst = d;
      tick();
      instr_valid = 1'b0;
      instr_op = ~op; instr_src1 = ~s1; instr_src2 = ~s2; instr_dst = ~d;
      check({tag, ".ready_busy"}, instr_ready, 0);
      check({tag, ".rd_add1"}, reg_read_add1, s1);
      check({tag, ".rd_add2"}, reg_read_add2, s2);
      check({tag, ".we_read"}, write_en, 0);
      tick();
      check({tag, ".we_exec"}, write_en, 0);
      tick();
      check({tag, ".we"}, write_en, 1);
      check({tag, ".done"}, done, 1);
      check({tag, ".wr_add"}, reg_write_add, d);
      check({tag, ".wr_data"}, reg_write_data, exp_data);
      check({tag, ".carry"}, carry, exp_c);
      check({tag, ".zero"}, zero, exp_z);
      tick();
      check({tag, ".we_after"}, write_en, 0);
      check({tag, ".done_after"}, done, 0);
      check({tag, ".ready_back"}, instr_ready, 1);
      check({tag, ".rf_commit"}, rf[d], exp_data);
   endtask

   logic [1:0] q_op  [3] = '{2'b00, 2'b01, 2'b11};
   logic [1:0] q_s1  [3] = '{2'd1, 2'd0, 2'd2};
   logic [1:0] q_s2  [3] = '{2'd1, 2'd1, 2'd3};
   logic [1:0] q_d   [3] = '{2'd1, 2'd3, 2'd0};
   logic [7:0] q_res [3] = '{8'hAA, 8'h00, 8'hFF};

   initial begin
      // Reset state
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst.ready", instr_ready, 1);
      check("rst.we", write_en, 0);
      check("rst.done", done, 0);
      check("rst.wr_data", reg_write_data, 0);
      check("rst.wr_add", reg_write_add, 0);
      check("rst.rd_add1", reg_read_add1, 0);
      check("rst.carry", carry, 0);
      check("rst.zero", zero, 0);

      preload(2'd0, 8'hAA); preload(2'd1, 8'h55); preload(2'd2, 8'h00); preload(2'd3, 8'h00);

      // 1: ADD 0,1 -> 2
      run("add1", 2'b00, 2'd0, 2'd1, 2'd2, 8'hFF, 1'b0, 1'b0);
      // 2: ADD with carry-out and zero result
      preload(2'd3, 8'h01);
      run("add_carry", 2'b00, 2'd2, 2'd3, 2'd0, 8'h00, 1'b1, 1'b1);
      preload(2'd0, 8'hAA);
      // 3: SUB with and without borrow
      run("sub_borrow", 2'b01, 2'd1, 2'd0, 2'd3, 8'hAB, 1'b1, 1'b0);
      run("sub", 2'b01, 2'd0, 2'd1, 2'd2, 8'h55, 1'b0, 1'b0);
      // 4: logic ops
      run("and", 2'b10, 2'd0, 2'd1, 2'd3, 8'h00, 1'b0, 1'b1);
      run("or", 2'b11, 2'd0, 2'd1, 2'd2, 8'hFF, 1'b0, 1'b0);

      // 5: valid held high, three queued instructions, garbage fields while busy
      for (int k = 0; k < 3; k++) begin
         check($sformatf("q%0d.ready_1", k), instr_ready, 1);
         instr_valid = 1'b1;
         instr_op = q_op[k]; instr_src1 = q_s1[k]; instr_src2 = q_s2[k]; instr_dst = q_d[k];
         tick();
         instr_op = 2'b01; instr_src1 = 2'd3; instr_src2 = 2'd2; instr_dst = 2'd2;
         check($sformatf("q%0d.ready_2", k), instr_ready, 0);
         tick();
         check($sformatf("q%0d.ready_3", k), instr_ready, 0);
         check($sformatf("q%0d.we_exec", k), write_en, 0);
         tick();
         check($sformatf("q%0d.ready_4", k), instr_ready, 0);
         check($sformatf("q%0d.we", k), write_en, 1);
         check($sformatf("q%0d.wr_add", k), reg_write_add, q_d[k]);
         check($sformatf("q%0d.wr_data", k), reg_write_data, q_res[k]);
         tick();
      end
      instr_valid = 1'b0;
      check("q.r1", rf[1], 8'hAA);
      check("q.r3", rf[3], 8'h00);
      check("q.r0", rf[0], 8'hFF);
      check("q.r2_untouched", rf[2], 8'hFF);

      // 6: reset during EXEC aborts the instruction
      preload(2'd0, 8'hAA); preload(2'd1, 8'h55); preload(2'd3, 8'h00);
      instr_valid = 1'b1; instr_op = 2'b00; instr_src1 = 2'd1; instr_src2 = 2'd2; instr_dst = 2'd3;
      tick();
      instr_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("abort.we", write_en, 0);
      check("abort.done", done, 0);
      check("abort.rd_add1", reg_read_add1, 0);
      check("abort.rd_add2", reg_read_add2, 0);
      check("abort.wr_data", reg_write_data, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("abort.idle_we%0d", c), write_en, 0);
         check($sformatf("abort.idle_rdy%0d", c), instr_ready, 1);
      end
      check("abort.r3_kept", rf[3], 8'h00);
      run("post_abort", 2'b00, 2'd1, 2'd2, 2'd3, 8'h54, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
